// File: rtl/press_sequence_controller_pkg.sv
// Shared types and display constants for the press sequence controller.
package press_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM1,
    ARMED,
    COUNT,
    DETECT
  } state_e;

  localparam logic [7:0] LED_OFF        = 8'h00;
  localparam logic [7:0] LED_ARM1       = 8'h01;
  localparam logic [7:0] LED_ARMED      = 8'h03;
  localparam logic [3:0] LED_COUNT_LO   = 4'b0011;
  localparam logic [7:0] LED_WALK_START = 8'h01;

  localparam int unsigned DETECT_STEPS = 8;

  // LED pattern shown while counting: press count in the high nibble.
  function automatic logic [7:0] count_leds(input logic [3:0] cnt);
    return {cnt, LED_COUNT_LO};
  endfunction

endpackage

// File: rtl/press_sequence_controller_debouncer.sv
// Button conditioning: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  logic       level_q;
  logic       rise_q;
  logic [7:0] run_q;

  // Accept a new level only after it has differed from the current one
  // for DEBOUNCE_CYCLES consecutive synchronized cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      rise_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (run_q == RUN_LAST) begin
          level_q <= sync_q[1];
          rise_q  <= sync_q[1];
          run_q   <= '0;
        end else begin
          run_q <= run_q + 8'd1;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/press_sequence_controller.sv
// Lab switch/button/LED controller: arming order sw1 then sw2, press
// counting inside a timeout window, walking-one display on detection.
module press_sequence_controller
  import press_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 200,
  parameter int unsigned PRESS_TARGET    = 3,
  parameter int unsigned STEP_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       button,
  output logic       detected_signal,
  output logic [7:0] outleds
);

  localparam logic [15:0] WIN_RELOAD   = 16'(WINDOW_CYCLES - 1);
  localparam logic [7:0]  STEP_LAST    = 8'(STEP_CYCLES - 1);
  localparam logic [3:0]  TARGET_CNT   = 4'(PRESS_TARGET);
  localparam logic [7:0]  LED_WALK_END = LED_WALK_START << (DETECT_STEPS - 1);

  logic [1:0]  rst_pipe_q;
  logic        rst_n;
  logic [1:0]  sw1_sync_q;
  logic [1:0]  sw2_sync_q;
  logic        sw1_s;
  logic        sw2_s;
  logic        both_on;
  logic        press;
  logic        unused_btn_level;

  state_e      state_q;
  logic [3:0]  press_cnt_q;
  logic [3:0]  cnt_next;
  logic [15:0] timer_q;
  logic [7:0]  step_q;
  logic [7:0]  leds_q;
  logic        det_q;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_pipe_q <= '0;
    end else begin
      rst_pipe_q <= {rst_pipe_q[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe_q[1];

  // Two-flop synchronizers for the arm switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw1_sync_q <= '0;
      sw2_sync_q <= '0;
    end else begin
      sw1_sync_q <= {sw1_sync_q[0], sw1};
      sw2_sync_q <= {sw2_sync_q[0], sw2};
    end
  end

  assign sw1_s    = sw1_sync_q[1];
  assign sw2_s    = sw2_sync_q[1];
  assign both_on  = sw1_s && sw2_s;
  assign cnt_next = press_cnt_q + 4'd1;

  // Only the rising-edge pulse drives the FSM; the debounced level is spare.
  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .reset     (rst_n),
    .din       (button),
    .level     (unused_btn_level),
    .rise_pulse(press)
  );

  // Sequence FSM; LEDs and detect flag are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      press_cnt_q <= '0;
      timer_q     <= '0;
      step_q      <= '0;
      leds_q      <= LED_OFF;
      det_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sw1_s && !sw2_s) begin
            state_q <= ARM1;
            leds_q  <= LED_ARM1;
          end
        end
        ARM1: begin
          if (!sw1_s) begin
            state_q <= IDLE;
            leds_q  <= LED_OFF;
          end else if (sw2_s) begin
            state_q <= ARMED;
            leds_q  <= LED_ARMED;
          end
        end
        ARMED: begin
          press_cnt_q <= '0;
          if (!both_on) begin
            state_q <= IDLE;
            leds_q  <= LED_OFF;
          end else if (press) begin
            if (PRESS_TARGET == 1) begin
              state_q <= DETECT;
              leds_q  <= LED_WALK_START;
              det_q   <= 1'b1;
              step_q  <= '0;
            end else begin
              state_q     <= COUNT;
              press_cnt_q <= 4'd1;
              timer_q     <= WIN_RELOAD;
              leds_q      <= count_leds(4'd1);
            end
          end
        end
        COUNT: begin
          // Switch drop beats press, and press beats timeout.
          if (!both_on) begin
            state_q     <= IDLE;
            press_cnt_q <= '0;
            leds_q      <= LED_OFF;
          end else if (press) begin
            if (cnt_next == TARGET_CNT) begin
              state_q     <= DETECT;
              press_cnt_q <= '0;
              leds_q      <= LED_WALK_START;
              det_q       <= 1'b1;
              step_q      <= '0;
            end else begin
              press_cnt_q <= cnt_next;
              timer_q     <= WIN_RELOAD;
              leds_q      <= count_leds(cnt_next);
            end
          end else if (timer_q == '0) begin
            state_q     <= ARMED;
            press_cnt_q <= '0;
            leds_q      <= LED_ARMED;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        DETECT: begin
          if (step_q == STEP_LAST) begin
            step_q <= '0;
            if (leds_q == LED_WALK_END) begin
              det_q   <= 1'b0;
              state_q <= both_on ? ARMED : IDLE;
              leds_q  <= both_on ? LED_ARMED : LED_OFF;
            end else begin
              leds_q <= {leds_q[6:0], leds_q[7]};
            end
          end else begin
            step_q <= step_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          leds_q  <= LED_OFF;
          det_q   <= 1'b0;
        end
      endcase
    end
  end

  assign detected_signal = det_q;
  assign outleds         = leds_q;

endmodule

// File: tb/tb_press_sequence_controller.sv
// Bench for press_sequence_controller: directed table, hand-written corner
// sequences, then randomized stimulus against a timestamp-based model.
module tb_press_sequence_controller;

  localparam int DEB  = 4;
  localparam int WIN  = 200;
  localparam int TGT  = 3;
  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       button = 1'b0;
  logic       detected_signal;
  logic [7:0] outleds;

  int vectors = 0;
  int miscompares = 0;

  press_sequence_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .WINDOW_CYCLES  (WIN),
    .PRESS_TARGET   (TGT),
    .STEP_CYCLES    (STEP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw1            (sw1),
    .sw2            (sw2),
    .button         (button),
    .detected_signal(detected_signal),
    .outleds        (outleds)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] exp_l, input logic exp_d);
    vectors++;
    if (outleds !== exp_l || detected_signal !== exp_d) begin
      miscompares++;
      $display("FAIL %s: outleds=%h det=%b, expected outleds=%h det=%b",
               nm, outleds, detected_signal, exp_l, exp_d);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ARM1 = 1, M_ARMED = 2, M_COUNT = 3, M_DETECT = 4;
  int m_mode, m_cnt, m_tpress, m_tdet, m_k, m_run;
  bit m_lvl, m_press;
  bit h1[2], h2[2], hb[2];

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_tpress = 0; m_tdet = 0; m_k = 0; m_run = 0;
    m_lvl = 1'b0; m_press = 1'b0;
    h1[0] = 1'b0; h1[1] = 1'b0; h2[0] = 1'b0; h2[1] = 1'b0; hb[0] = 1'b0; hb[1] = 1'b0;
  endtask

  // One clock edge; inputs are the values present at that edge.
  task automatic model_step(input bit i1, input bit i2, input bit ib);
    bit s1, s2, b, pr, on;
    s1 = h1[1]; s2 = h2[1]; b = hb[1]; pr = m_press;
    on = s1 && s2;
    m_press = 1'b0;
    if (b != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = b; m_run = 0; m_press = b;
      end
    end else m_run = 0;
    h1[1] = h1[0]; h1[0] = i1;
    h2[1] = h2[0]; h2[0] = i2;
    hb[1] = hb[0]; hb[0] = ib;
    m_k++;
    case (m_mode)
      M_IDLE:  if (s1 && !s2) m_mode = M_ARM1;
      M_ARM1:  if (!s1) m_mode = M_IDLE; else if (s2) m_mode = M_ARMED;
      M_ARMED: begin
        if (!on) m_mode = M_IDLE;
        else if (pr) begin
          m_cnt = 1; m_tpress = m_k; m_mode = M_COUNT;
          if (m_cnt == TGT) begin m_mode = M_DETECT; m_tdet = m_k; m_cnt = 0; end
        end
      end
      M_COUNT: begin
        if (!on) begin m_mode = M_IDLE; m_cnt = 0; end
        else if (pr) begin
          m_cnt++; m_tpress = m_k;
          if (m_cnt == TGT) begin m_mode = M_DETECT; m_tdet = m_k; m_cnt = 0; end
        end else if (m_k - m_tpress >= WIN) begin
          m_mode = M_ARMED; m_cnt = 0;
        end
      end
      default: if (m_k - m_tdet == 8 * STEP) m_mode = on ? M_ARMED : M_IDLE;
    endcase
  endtask

  function automatic logic [7:0] model_leds();
    case (m_mode)
      M_IDLE:  return 8'h00;
      M_ARM1:  return 8'h01;
      M_ARMED: return 8'h03;
      M_COUNT: return 8'((m_cnt << 4) + 3);
      default: return 8'(1 << ((m_k - m_tdet) / STEP));
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic       sw1;
    logic       sw2;
    logic       btn;
    int         hold;
    logic [7:0] leds;
    logic       det;
  } vec_t;

  localparam int NT = 33;
  vec_t tbl[NT];

  initial begin
    int seg_left;
    bit seg_bounce, seg_lvl;

    tbl[0]  = '{1'b0, 1'b0, 1'b0,   2, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0,   2, 8'h00, 1'b0};  // sw1: not yet
    tbl[2]  = '{1'b1, 1'b0, 1'b0,   1, 8'h01, 1'b0};  // 3rd edge
    tbl[3]  = '{1'b1, 1'b1, 1'b0,   2, 8'h01, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0,   1, 8'h03, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1,   6, 8'h03, 1'b0};  // press pending
    tbl[6]  = '{1'b1, 1'b1, 1'b1,   1, 8'h13, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0,  10, 8'h13, 1'b0};  // fall: no press
    tbl[8]  = '{1'b1, 1'b1, 1'b1,   7, 8'h23, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0,  10, 8'h23, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1,   6, 8'h23, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1,   1, 8'h01, 1'b1};  // DETECT
    tbl[12] = '{1'b1, 1'b1, 1'b1,   7, 8'h01, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1,   1, 8'h02, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0,  55, 8'h80, 1'b1};  // 63 cycles in
    tbl[15] = '{1'b1, 1'b1, 1'b0,   1, 8'h03, 1'b0};  // 64: back to ARMED
    tbl[16] = '{1'b1, 1'b1, 1'b1,   7, 8'h13, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 199, 8'h13, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0,   1, 8'h03, 1'b0};  // timeout
    tbl[19] = '{1'b1, 1'b1, 1'b1,   7, 8'h13, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b1,   2, 8'h13, 1'b0};  // sw1 drop in COUNT
    tbl[21] = '{1'b0, 1'b1, 1'b1,   1, 8'h00, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b1,  10, 8'h00, 1'b0};  // sw2 first
    tbl[23] = '{1'b1, 1'b0, 1'b1,   2, 8'h00, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 1'b1,   1, 8'h01, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 1'b1,   3, 8'h03, 1'b0};  // held button: no press
    tbl[26] = '{1'b1, 1'b1, 1'b0,  10, 8'h03, 1'b0};
    tbl[27] = '{1'b1, 1'b1, 1'b1,   7, 8'h13, 1'b0};
    tbl[28] = '{1'b1, 1'b1, 1'b0, 193, 8'h13, 1'b0};
    tbl[29] = '{1'b1, 1'b1, 1'b1,   6, 8'h13, 1'b0};
    tbl[30] = '{1'b1, 1'b1, 1'b1,   1, 8'h23, 1'b0};  // press on timeout cycle
    tbl[31] = '{1'b1, 1'b1, 1'b0, 150, 8'h23, 1'b0};
    tbl[32] = '{1'b1, 1'b1, 1'b0,  50, 8'h03, 1'b0};

    // Reset held with inputs toggling: outputs stay dark.
    for (int i = 0; i < 10; i++) begin
      sw1 = i[0]; sw2 = i[1]; button = i[2];
      @(posedge clk); #1;
      check("reset_hold", 8'h00, 1'b0);
    end
    sw1 = 1'b0; sw2 = 1'b0; button = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_reset", 8'h00, 1'b0);

    for (int i = 0; i < NT; i++) begin
      sw1 = tbl[i].sw1; sw2 = tbl[i].sw2; button = tbl[i].btn;
      repeat (tbl[i].hold) @(posedge clk);
      #1;
      check($sformatf("tbl%0d", i), tbl[i].leds, tbl[i].det);
    end

    // Bounce: per-cycle toggling, then held high -> exactly one press.
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0);
      @(posedge clk); #1;
    end
    button = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("bounce_one", 8'h13, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("bounce_hold", 8'h13, 1'b0);
    button = 1'b0;
    repeat (12) @(posedge clk); #1;
    button = 1'b1;
    repeat (3) @(posedge clk); #1;
    button = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("glitch3", 8'h13, 1'b0);
    button = 1'b1;
    repeat (4) @(posedge clk); #1;
    button = 1'b0;
    repeat (12) @(posedge clk); #1;
    check("pulse4", 8'h23, 1'b0);

    // Third press, then async reset in the middle of the walk.
    button = 1'b1;
    repeat (7) @(posedge clk); #1;
    check("det_enter", 8'h01, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("det_walk", 8'h04, 1'b1);
    #2 reset = 1'b0;
    #1 check("rst_async", 8'h00, 1'b0);
    sw1 = 1'b0; sw2 = 1'b0; button = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("rst_held", 8'h00, 1'b0);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("rst_release", 8'h00, 1'b0);

    // Randomized run against the model.
    model_reset();
    seg_left = 0; seg_bounce = 1'b0; seg_lvl = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (n == 3000) begin
        sw1 = 1'b0; sw2 = 1'b0; button = 1'b0;
        reset = 1'b0;
        #1 check("rand_reset", 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        model_reset();
        seg_left = 0;
      end
      if (seg_left == 0) begin
        seg_left = $urandom_range(1, 40);
        if ($urandom_range(0, 9) == 0) seg_left = $urandom_range(150, 260);
        seg_bounce = ($urandom_range(0, 3) == 0);
        seg_lvl = 1'($urandom_range(0, 1));
      end
      seg_left--;
      button = seg_bounce ? 1'($urandom_range(0, 1)) : seg_lvl;
      if (sw1 && $urandom_range(0, 299) == 0) sw1 = 1'b0;
      if (sw2 && $urandom_range(0, 299) == 0) sw2 = 1'b0;
      if (!sw1 && $urandom_range(0, 29) == 0) sw1 = 1'b1;
      if (sw1 && !sw2 && $urandom_range(0, 29) == 0) sw2 = 1'b1;
      @(posedge clk);
      model_step(sw1, sw2, button);
      #1;
      check("rand", model_leds(), m_mode == M_DETECT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/press_sequence_controller.md
# press_sequence_controller

Controller for the lab switch/button/LED datapath. It synchronizes and debounces the board inputs and enforces an arming order (sw1, then sw2). It counts button presses inside a timeout window. When the target count is reached it asserts detected_signal and drives a walking-one display on the 8-bit LED bank.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a new button level (1..255)
- WINDOW_CYCLES, 200: press timeout window in clk cycles (2..65535)
- PRESS_TARGET, 3: presses needed to detect (1..15)
- STEP_CYCLES, 8: clk cycles per walking-one LED step (1..255)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- sw1  input  1  arm switch 1, asynchronous
- sw2  input  1  arm switch 2, asynchronous
- button  input  1  push button, asynchronous, bouncy
- detected_signal  output  1  high for the whole DETECT display
- outleds  output  8  LED bank, registered

## Operation
- Input conditioning:
  - sw1, sw2 and button each pass through a 2-flop synchronizer.
  - Debounced button level changes only after the synchronized level differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old level restarts the run count.
  - press is a 1-cycle pulse on a debounced rising edge. Falling edges produce nothing.
- States: IDLE, ARM1, ARMED, COUNT, DETECT. The transitions below use synchronized switch values.
- IDLE: outleds=8'h00.
  - sw1=1 and sw2=0 → ARM1.
  - sw1 and sw2 high together (same cycle, or sw2 first) → stay IDLE until sw2 drops.
- ARM1: outleds=8'h01.
  - sw1=0 → IDLE.
  - sw2=1 → ARMED.
- ARMED: outleds=8'h03, press_cnt=0.
  - Either switch low → IDLE.
  - press → COUNT with press_cnt=1 and window timer loaded with WINDOW_CYCLES-1.
  - If PRESS_TARGET=1, press goes straight to DETECT.
- COUNT: outleds={press_cnt[3:0], 4'b0011}. Timer decrements once per cycle.
  - press → press_cnt+1 and timer reloaded. If the new count equals PRESS_TARGET → DETECT.
  - Timer at 0 with no press → ARMED, press_cnt=0.
  - Either switch low → IDLE; this has priority over press and timeout.
  - Press in the same cycle as timer=0: the press wins.
- DETECT: detected_signal=1, press_cnt cleared, presses and switches ignored.
  - outleds starts at 8'h01 and rotates left every STEP_CYCLES cycles through 8'h80, giving 8 steps.
  - After the 8h80 step completes: → ARMED if both switches are high, else → IDLE.
- press_cnt never wraps; the maximum is PRESS_TARGET.

## Timing
- Reset asserted, at any time and in any state: state=IDLE, outleds=8'h00, detected_signal=0. All synchronizers, debounce, timer, step and press counters clear.
  - Reset mid-DETECT aborts the display immediately.
- Release of reset is synchronized internally; first active edge is the one after release.
- Switch change → state/outleds change: 3 clk edges (2 sync + 1 state register).
- Clean button rise → press: 2 sync + DEBOUNCE_CYCLES cycles. State/outleds update 1 edge later.
- detected_signal and outleds are both registered and change on the same edge as the state.
- DETECT lasts exactly 8×STEP_CYCLES cycles.
- Window: the last press must come no later than WINDOW_CYCLES cycles after the previous accepted press; the next cycle times out.

## Structure
- Package press_seq_pkg holds:
  - state enum (IDLE, ARM1, ARMED, COUNT, DETECT)
  - LED constants LED_OFF=8'h00, LED_ARM1=8'h01, LED_ARMED=8'h03, LED_COUNT_LO=4'b0011, LED_WALK_START=8'h01
  - DETECT_STEPS=8
- Sub-module button_debouncer (param DEBOUNCE_CYCLES; ports clk, reset, din, level, rise_pulse) contains the synchronizer and stability counter.
- The switch synchronizers and FSM stay in the top module.

## Test plan
- Reset/idle: hold reset low 100 ns, toggle all inputs → outleds=8'h00, detected_signal=0 throughout; IDLE after release.
- Arming order:
  - sw1 then sw2 500 ns apart → outleds 8'h00→8'h01→8'h03, each change 3 edges after the switch.
  - sw2 before sw1 → stays 8'h00 until sw2 drops.
- Detection: armed, 3 clean presses 600 ns apart (default params) → outleds 8'h13, 8'h23, then DETECT. Walk 8'h01..8'h80 at 8-cycle steps with detected_signal high 64 cycles, then back to 8'h03.
- Timeout: armed, 1 press, wait 200+ cycles → outleds 8'h13 then 8'h03; next press shows 8'h13 again. Press on the timeout cycle → count 2.
- Bounce: button toggling every cycle for 10 cycles, then held high → exactly one press; glitches shorter than 4 cycles → no press.
- Aborts: sw1 dropped in COUNT → IDLE/8'h00. Reset pulse during DETECT → outleds=8'h00 and detected_signal=0 asynchronously, without waiting for clk.
